pb_conditioner: RTL and testbench
=================================

# pb_conditioner

Conditions the raw active-low DE10-Lite pushbutton inputs before user logic sees them. These are the `key` signals delivered by the JTAG pin IP. Each key is synchronized, debounced by a per-key state machine, and turned into a clean held level plus single-cycle press, release and (optionally) long-press pulses. It sits between the pin IP's `key` output and the user design, in place of a direct `.key` connection in the board top level.

## Interface

Parameters:
- `N_KEYS`, 2: number of pushbutton channels.
- `DB_CYCLES`, 1_000_000: number of stable cycles needed to accept a level change (20 ms at 50 MHz); must be ≥ 2.
- `LONG_CYCLES`, 50_000_000: cycles in HELD before a long-press pulse fires (1 s at 50 MHz); must be > `DB_CYCLES`.

Ports:
- `max10_clk1_50`, input, 1: the only clock; all state is on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `key_n`, input, `N_KEYS`: raw pushbuttons, active-low (0 = pressed), asynchronous to the clock.
- `pressed`, output, `N_KEYS`: debounced level, active-high.
- `press_pulse`, output, `N_KEYS`: one-cycle strobe on an accepted press.
- `release_pulse`, output, `N_KEYS`: one-cycle strobe on an accepted release.
- `long_pulse`, output, `N_KEYS`: one-cycle strobe when a press has been held for `LONG_CYCLES`.

## Operation

- Each channel has its own two-flop synchronizer. Its reset value is 1 (released). The synchronized signal is `s` (1 = pressed after inversion).
- Per-channel FSM states: IDLE, DB_PRESS, HELD, DB_RELEASE.
- IDLE: debounce counter = 0. If `s` = 1, go to DB_PRESS with count = 1.
- DB_PRESS:
  - If `s` = 0, return to IDLE and clear the count (the glitch is rejected).
  - If `s` = 1 and count = `DB_CYCLES`−1, go to HELD.
  - Otherwise, increment the count.
- HELD: `pressed` = 1. The hold counter increments every cycle and saturates at `LONG_CYCLES`. If `s` = 0, go to DB_RELEASE with count = 1.
- DB_RELEASE:
  - If `s` = 1, return to HELD. The hold counter is preserved, so a bounce on release does not re-arm the long press.
  - If `s` = 0 and count = `DB_CYCLES`−1, go to IDLE.
  - Otherwise, increment the count.
- `pressed` is 1 in HELD and DB_RELEASE, and 0 in IDLE and DB_PRESS.
- `press_pulse` is asserted for exactly one cycle on the DB_PRESS→HELD transition. The hold counter is cleared to 0 on that transition.
- `release_pulse` is asserted for exactly one cycle on the DB_RELEASE→IDLE transition.
- `long_pulse` is asserted for exactly one cycle when the hold counter reaches `LONG_CYCLES`−1 while in HELD or DB_RELEASE. It is never asserted again within the same press.
- Channels are fully independent. Events on several channels in the same cycle all produce their pulses in that cycle.
- Counter widths are `$clog2(DB_CYCLES+1)` and `$clog2(LONG_CYCLES+1)`. Counters never wrap.

## Timing

- Reset values:
  - All outputs are 0 and all FSMs are in IDLE.
  - Synchronizer flops are 1, and all counters are 0.
- Reset asserted mid-operation aborts immediately. No release pulse is generated. After reset deasserts, a key that is still held must debounce again and will produce a fresh `press_pulse`.
- Latency from a clean `key_n` falling edge to `press_pulse`: 2 synchronizer cycles + `DB_CYCLES` cycles. The same formula applies to `release_pulse`.
- `long_pulse` occurs `LONG_CYCLES`−1 cycles after `press_pulse`.
- All outputs are registered, and pulses are never wider than one cycle.

## Configuration

- `PB_LONG_PRESS_EN` defined: the hold counter and `long_pulse` logic are compiled in, as described above.
- `PB_LONG_PRESS_EN` undefined:
  - The hold counter is removed and `long_pulse` is tied to 0.
  - `LONG_CYCLES` is ignored, and its constraint against `DB_CYCLES` is not checked.
  - All other behaviour is identical.

## Structure

- Package `pb_cond_pkg`: the `pb_state_t` enum (IDLE, DB_PRESS, HELD, DB_RELEASE) and the default cycle constants `PB_DB_CYCLES_DEF` and `PB_LONG_CYCLES_DEF`.
- Sub-module `pb_channel`: one synchronizer, FSM and counter set for a single key. `pb_conditioner` instantiates `N_KEYS` copies in a generate loop.
- Top-level hookup: `pb_conditioner` takes `key` from the pin IP, and the user design reads its outputs instead of the raw keys.

## Test plan

Run all scenarios with `DB_CYCLES`=4, `LONG_CYCLES`=16 and `PB_LONG_PRESS_EN` defined. Run scenario 4 again with the macro undefined.

1. Reset: assert `reset_n`=0 with `key_n`=2'b00 → all outputs 0. Deassert, hold `key_n` low → `press_pulse`[0] and `press_pulse`[1] both high exactly 6 cycles after release of reset.
2. Clean press: `key_n`[0] 1→0 and held 10 cycles → `press_pulse`[0] high for one cycle 6 cycles after the edge, and `pressed`[0]=1 from then on.
3. Glitch rejection: `key_n`[0] low for 3 cycles, then high → no pulse, `pressed`[0] stays 0, and the FSM returns to IDLE.
4. Long press: hold `key_n`[1] low for 30 cycles → `long_pulse`[1] exactly once, 15 cycles after `press_pulse`[1]. With the macro undefined, `long_pulse` is never asserted.
5. Release bounce: while held, toggle `key_n`[0] high 2 cycles / low 1 cycle / high 10 cycles → exactly one `release_pulse`[0], 6 cycles after the final rising edge, and no extra `press_pulse`.
6. Mid-operation reset: assert `reset_n` while in HELD → `pressed`=0 immediately and no `release_pulse`.

Source files
------------

// File: rtl/pb_cond_pkg.sv
// rtl/pb_cond_pkg.sv - shared state encoding and default timing constants for pb_conditioner
package pb_cond_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } pb_state_t;

    // 20 ms debounce and 1 s long press at 50 MHz
    localparam int PB_DB_CYCLES_DEF   = 1_000_000;
    localparam int PB_LONG_CYCLES_DEF = 50_000_000;

endpackage

// File: rtl/pb_channel.sv
// rtl/pb_channel.sv - one pushbutton: synchronizer, debounce FSM, pulses; long press under PB_LONG_PRESS_EN
module pb_channel
    import pb_cond_pkg::*;
#(
    parameter int DB_CYCLES   = PB_DB_CYCLES_DEF,
    parameter int LONG_CYCLES = PB_LONG_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_pressed,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_long_pulse
);

    localparam int              DB_W    = $clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [1:0]      r_sync;
    logic            w_s;
    pb_state_t       r_state;
    pb_state_t       w_state_nxt;
    logic [DB_W-1:0] r_db_cnt;
    logic [DB_W-1:0] w_db_cnt_nxt;
    logic            w_press_evt;
    logic            w_release_evt;
    logic            r_pressed;
    logic            r_press_pulse;
    logic            r_release_pulse;

    // Resets to released so a key held through reset debounces afresh
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_key_n};
        end
    end

    assign w_s = ~r_sync[1];

    always_comb begin
        w_state_nxt   = r_state;
        w_db_cnt_nxt  = r_db_cnt;
        w_press_evt   = 1'b0;
        w_release_evt = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_db_cnt_nxt = '0;
                if (w_s) begin
                    w_state_nxt  = DB_PRESS;
                    w_db_cnt_nxt = DB_W'(1);
                end
            end
            DB_PRESS: begin
                if (!w_s) begin
                    w_state_nxt  = IDLE;
                    w_db_cnt_nxt = '0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt  = HELD;
                    w_db_cnt_nxt = '0;
                    w_press_evt  = 1'b1;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + DB_W'(1);
                end
            end
            HELD: begin
                if (!w_s) begin
                    w_state_nxt  = DB_RELEASE;
                    w_db_cnt_nxt = DB_W'(1);
                end
            end
            DB_RELEASE: begin
                if (w_s) begin
                    w_state_nxt  = HELD;
                    w_db_cnt_nxt = '0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt   = IDLE;
                    w_db_cnt_nxt  = '0;
                    w_release_evt = 1'b1;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + DB_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= IDLE;
            r_db_cnt        <= '0;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_db_cnt        <= w_db_cnt_nxt;
            r_pressed       <= (w_state_nxt == HELD) || (w_state_nxt == DB_RELEASE);
            r_press_pulse   <= w_press_evt;
            r_release_pulse <= w_release_evt;
        end
    end

    assign o_pressed       = r_pressed;
    assign o_press_pulse   = r_press_pulse;
    assign o_release_pulse = r_release_pulse;

`ifdef PB_LONG_PRESS_EN
    localparam int                HOLD_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 2);

    logic [HOLD_W-1:0] r_hold;
    logic              r_long_pulse;
    logic              w_holding;

    assign w_holding = (r_state == HELD) || (r_state == DB_RELEASE);

    // Saturation keeps the counter from passing the fire point twice in one press
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold       <= '0;
            r_long_pulse <= 1'b0;
        end else begin
            r_long_pulse <= w_holding && (r_hold == HOLD_FIRE);
            if (w_press_evt) begin
                r_hold <= '0;
            end else if (w_holding && (r_hold != HOLD_MAX)) begin
                r_hold <= r_hold + HOLD_W'(1);
            end
        end
    end

    assign o_long_pulse = r_long_pulse;
`else
    logic w_unused_long;
    assign w_unused_long = (LONG_CYCLES > 0);
    assign o_long_pulse  = 1'b0;
`endif

endmodule

// File: rtl/pb_conditioner.sv
// rtl/pb_conditioner.sv - DE10-Lite pushbutton conditioner, N_KEYS independent channels; long press under PB_LONG_PRESS_EN
module pb_conditioner
    import pb_cond_pkg::*;
#(
    parameter int N_KEYS      = 2,
    parameter int DB_CYCLES   = PB_DB_CYCLES_DEF,
    parameter int LONG_CYCLES = PB_LONG_CYCLES_DEF
) (
    input  logic              max10_clk1_50,
    input  logic              reset_n,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] pressed,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        pb_channel #(
            .DB_CYCLES  (DB_CYCLES),
            .LONG_CYCLES(LONG_CYCLES)
        ) u_ch (
            .i_clk          (max10_clk1_50),
            .i_rst_n        (reset_n),
            .i_key_n        (key_n[g]),
            .o_pressed      (pressed[g]),
            .o_press_pulse  (press_pulse[g]),
            .o_release_pulse(release_pulse[g]),
            .o_long_pulse   (long_pulse[g])
        );
    end

endmodule

// File: tb/tb_pb_conditioner.sv
// tb/tb_pb_conditioner.sv - directed vector bench for pb_conditioner, DB_CYCLES=4 LONG_CYCLES=16
module tb_pb_conditioner;

`ifdef PB_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    typedef struct {
        logic       rst_n;
        logic [1:0] key_n;
        logic       async_chk;
        logic [1:0] pr;
        logic [1:0] pp;
        logic [1:0] rp;
        logic [1:0] lp;
        int         reps;
    } vec_t;

    logic       clk;
    logic       reset_n;
    logic [1:0] key_n;
    logic [1:0] pressed;
    logic [1:0] press_pulse;
    logic [1:0] release_pulse;
    logic [1:0] long_pulse;

    int   total;
    int   bad;
    vec_t tbl[$];

    pb_conditioner #(
        .N_KEYS     (2),
        .DB_CYCLES  (4),
        .LONG_CYCLES(16)
    ) dut (
        .max10_clk1_50(clk),
        .reset_n      (reset_n),
        .key_n        (key_n),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [1:0] k, input logic a, input logic [1:0] pr,
                       input logic [1:0] pp, input logic [1:0] rp, input logic [1:0] lp, input int n);
        vec_t v;
        v.rst_n = r; v.key_n = k; v.async_chk = a;
        v.pr = pr; v.pp = pp; v.rp = rp; v.lp = lp; v.reps = n;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b (pressed,press,release,long)", name, got, exp);
        end
    endtask

    task automatic wait_pulse(input string name, input int which, input int exp_lat);
        int lat;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk); #1;
            if ((which == 0 && press_pulse[0]) || (which == 1 && release_pulse[0])) lat = i;
        end
        total++;
        if (lat != exp_lat) begin
            bad++;
            $display("FAIL %s latency got=%0d exp=%0d", name, lat, exp_lat);
        end
        @(posedge clk); #1;
        check({name, "_width"}, {6'b0, press_pulse[0], release_pulse[0]}, 8'b0);
    endtask

    initial begin
        logic [1:0] lpx;
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        key_n   = 2'b00;
        lpx     = LONG_EN ? 2'b11 : 2'b00;

        // reset with both keys down, then both debounce and long-press together
        add(0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3);
        add(1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 5);
        add(1, 2'b00, 0, 2'b11, 2'b11, 2'b00, 2'b00, 1);
        add(1, 2'b00, 0, 2'b11, 2'b00, 2'b00, 2'b00, 14);
        add(1, 2'b00, 0, 2'b11, 2'b00, 2'b00, lpx,   1);
        add(1, 2'b11, 0, 2'b11, 2'b00, 2'b00, 2'b00, 5);
        add(1, 2'b11, 0, 2'b00, 2'b00, 2'b11, 2'b00, 1);
        add(1, 2'b11, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3);
        // clean press on key 0, then release with a bounce
        add(1, 2'b10, 0, 2'b00, 2'b00, 2'b00, 2'b00, 5);
        add(1, 2'b10, 0, 2'b01, 2'b01, 2'b00, 2'b00, 1);
        add(1, 2'b10, 0, 2'b01, 2'b00, 2'b00, 2'b00, 4);
        add(1, 2'b11, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2);
        add(1, 2'b10, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1);
        add(1, 2'b11, 0, 2'b01, 2'b00, 2'b00, 2'b00, 5);
        add(1, 2'b11, 0, 2'b00, 2'b00, 2'b01, 2'b00, 1);
        add(1, 2'b11, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4);
        // 3-cycle glitch on key 0 is rejected
        add(1, 2'b10, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3);
        add(1, 2'b11, 0, 2'b00, 2'b00, 2'b00, 2'b00, 6);
        // key 1 held 30 cycles: one long pulse 15 cycles after press
        add(1, 2'b01, 0, 2'b00, 2'b00, 2'b00, 2'b00, 5);
        add(1, 2'b01, 0, 2'b10, 2'b10, 2'b00, 2'b00, 1);
        add(1, 2'b01, 0, 2'b10, 2'b00, 2'b00, 2'b00, 14);
        add(1, 2'b01, 0, 2'b10, 2'b00, 2'b00, lpx & 2'b10, 1);
        add(1, 2'b01, 0, 2'b10, 2'b00, 2'b00, 2'b00, 9);
        add(1, 2'b11, 0, 2'b10, 2'b00, 2'b00, 2'b00, 5);
        add(1, 2'b11, 0, 2'b00, 2'b00, 2'b10, 2'b00, 1);
        add(1, 2'b11, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3);
        // reset while key 0 is held: immediate clear, no release, fresh press after
        add(1, 2'b10, 0, 2'b00, 2'b00, 2'b00, 2'b00, 5);
        add(1, 2'b10, 0, 2'b01, 2'b01, 2'b00, 2'b00, 1);
        add(1, 2'b10, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3);
        add(0, 2'b10, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3);
        add(1, 2'b10, 0, 2'b00, 2'b00, 2'b00, 2'b00, 5);
        add(1, 2'b10, 0, 2'b01, 2'b01, 2'b00, 2'b00, 1);
        add(1, 2'b10, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2);
        add(1, 2'b11, 0, 2'b01, 2'b00, 2'b00, 2'b00, 5);
        add(1, 2'b11, 0, 2'b00, 2'b00, 2'b01, 2'b00, 1);
        add(1, 2'b11, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2);

        foreach (tbl[v]) begin
            for (int r = 0; r < tbl[v].reps; r++) begin
                @(negedge clk);
                reset_n = tbl[v].rst_n;
                key_n   = tbl[v].key_n;
                if (tbl[v].async_chk && r == 0) begin
                    #1;
                    check($sformatf("vec%0d_async", v),
                          {pressed, press_pulse, release_pulse, long_pulse},
                          {tbl[v].pr, tbl[v].pp, tbl[v].rp, tbl[v].lp});
                end
                @(posedge clk); #1;
                check($sformatf("vec%0d_cyc%0d", v, r),
                      {pressed, press_pulse, release_pulse, long_pulse},
                      {tbl[v].pr, tbl[v].pp, tbl[v].rp, tbl[v].lp});
            end
        end

        // measured press and release latency on key 0
        @(negedge clk);
        key_n = 2'b10;
        wait_pulse("lat_press", 0, 6);
        @(negedge clk);
        key_n = 2'b11;
        wait_pulse("lat_release", 1, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
